// File: rtl/fetch_queue_frontend_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// Contents:
//   XLEN_DEFAULT       default address/instruction width
//   INST_BYTES_DEFAULT default PC increment in bytes
//   fetch_entry_t      {pc, inst} pair held by the fetch queue
//   align_pc()         clears the sub-instruction address bits of a PC
package frontend_pkg;

    localparam int unsigned XLEN_DEFAULT       = 32;
    localparam int unsigned INST_BYTES_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

    // Clear the low log2(inst_bytes) bits; inst_bytes is a power of two.
    function automatic logic [63:0] align_pc(input logic [63:0] pc,
                                             input int unsigned inst_bytes);
        logic [63:0] mask;
        mask = 64'(inst_bytes) - 64'd1;
        return pc & ~mask;
    endfunction

endpackage

// File: rtl/fetch_queue_frontend_if.sv
// Bus bundle between the fetch front end, instruction memory and OF stage.
// Signals:
//   imem_addr/imem_rdata        combinational instruction-memory read
//   redirect_valid/redirect_pc  branch redirect request
//   of_valid/of_ready           head handshake toward OF
//   of_pc/of_inst               head entry contents
//   q_count                     queue occupancy, 0..DEPTH
// Modports: master = front end, slave = memory/OF/branch side.
interface fetch_queue_frontend_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    logic [XLEN-1:0]          imem_addr;
    logic [XLEN-1:0]          imem_rdata;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     of_valid;
    logic                     of_ready;
    logic [XLEN-1:0]          of_pc;
    logic [XLEN-1:0]          of_inst;
    logic [$clog2(DEPTH):0]   q_count;

    modport master (
        output imem_addr, of_valid, of_pc, of_inst, q_count,
        input  imem_rdata, redirect_valid, redirect_pc, of_ready
    );

    modport slave (
        input  imem_addr, of_valid, of_pc, of_inst, q_count,
        output imem_rdata, redirect_valid, redirect_pc, of_ready
    );
endinterface

// File: rtl/fetch_queue_frontend_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push/pop/flush  enqueue, dequeue, discard all entries (flush wins)
//   din/dout        write data / head entry (registered storage)
//   count/full/empty occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo import frontend_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    parameter  type         entry_t = fetch_entry_t,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    entry_t        mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == CW'(0));
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push into a full queue is accepted only when the head leaves the same cycle.
    assign do_pop  = pop  && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    // Read/write pointer update; flush returns both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= CW'(0);
            rd_ptr <= CW'(0);
        end else if (flush) begin
            wr_ptr <= CW'(0);
            rd_ptr <= CW'(0);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/fetch_queue_frontend.sv
// Instruction fetch front end: PC generator, instruction-memory request and
// a DEPTH-entry fetch queue presented to OF with a valid/ready handshake.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       fetch_queue_frontend_if.master (imem, redirect, OF, q_count)
// A redirect flushes the queue, reloads the PC with the aligned target and
// blocks both push and pop for that cycle.
module fetch_queue_frontend import frontend_pkg::*; #(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     INST_BYTES = INST_BYTES_DEFAULT
) (
    input logic                    clk,
    input logic                    rst,
    fetch_queue_frontend_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [63:0]     redirect_aligned;
    entry_t          wr_entry;
    entry_t          head;
    logic            push;
    logic            pop;
    logic            flush;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;

    assign flush    = bus.redirect_valid;
    assign wr_entry = '{pc: pc_q, inst: bus.imem_rdata};

    // Handshake and enqueue decisions; redirect suppresses both.
    always_comb begin
        bus.of_valid = !empty && !bus.redirect_valid;
        pop          = bus.of_valid && bus.of_ready;
        push         = !bus.redirect_valid && (!full || pop);
    end

    // Redirect target with the sub-instruction offset dropped.
    always_comb begin
        redirect_aligned = align_pc(64'(bus.redirect_pc), INST_BYTES);
    end

    // Fetch PC: redirect reload, sequential advance on push, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= redirect_aligned[XLEN-1:0];
        end else if (push) begin
            pc_q <= pc_q + XLEN'(INST_BYTES);
        end else begin
            pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.imem_addr = pc_q;
    assign bus.of_pc     = head.pc;
    assign bus.of_inst   = head.inst;
    assign bus.q_count   = count;
endmodule
